// File: rtl/ula_seq.sv
// ula_seq: registered arithmetic/logic unit with valid/ready handshakes on both sides.
// ADD, SUB, AND, OR, XOR, SHL and SHR finish one cycle after accept. MUL is a shift-add
// multiply that walks one multiplier bit per cycle over WIDTH cycles.
//
// Ports
//   CLK        clock; all state updates on the rising edge
//   RST        synchronous active-high reset
//   IN_VALID   operand/opcode offer from the source
//   IN_READY   the unit can take an operation this cycle
//   A, B       operands; shifts use only B[SHW-1:0]
//   OP         opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//   OUT_VALID  Result and flags hold a finished operation
//   OUT_READY  the consumer takes the result this cycle
//   Result     registered result
//   FLAG_Z/N   zero / sign of Result
//   FLAG_C     carry, borrow, last bit shifted out, or nonzero high half of the product
//   FLAG_V     signed overflow for ADD/SUB, 0 otherwise
module ula_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Result,
  output logic             FLAG_Z,
  output logic             FLAG_N,
  output logic             FLAG_C,
  output logic             FLAG_V
);

  localparam int unsigned SHW = $clog2(WIDTH);
  // The counter must hold the value WIDTH itself.
  localparam int unsigned CW  = SHW + 1;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   res_q, res_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic accept;
  logic op_is_mul;
  logic last_step;

  assign accept    = IN_VALID && IN_READY;
  assign op_is_mul = (OP == OpMul);
  assign last_step = (state_q == StBusy) && (cnt_q == CW'(1));

  // Single-cycle operations, evaluated on the live inputs and captured on accept.
  logic [WIDTH:0]     add_full, sub_full;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] shl_ext, shr_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} - {1'b0, B};  // MSB is the borrow
  assign shamt    = B[SHW-1:0];
  // Shifting into a double-width window leaves the last bit shifted out at the boundary,
  // and a zero there when the amount is 0.
  assign shl_ext  = {{WIDTH{1'b0}}, A} << shamt;
  assign shr_ext  = {A, {WIDTH{1'b0}}} >> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (OP)
      OpAdd: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
      end
      OpSub: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
      end
      OpAnd: alu_res = A & B;
      OpOr:  alu_res = A | B;
      OpXor: alu_res = A ^ B;
      OpShl: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OpShr: begin
        alu_res = shr_ext[2*WIDTH-1:WIDTH];
        alu_c   = shr_ext[WIDTH-1];
      end
      default: ;  // MUL goes through the sequential datapath
    endcase
  end

  // One shift-add step of the multiplier.
  logic [2*WIDTH-1:0] acc_step;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = op_is_mul ? StBusy : StDone;
      end
      StBusy: begin
        if (last_step) state_d = StDone;
      end
      StDone: begin
        if (OUT_READY) begin
          if (accept) state_d = op_is_mul ? StBusy : StDone;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      StIdle:  IN_READY = !RST;
      StBusy:  IN_READY = 1'b0;
      StDone: begin
        IN_READY  = !RST && OUT_READY;
        OUT_VALID = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next state: result/flags change only when a new result is produced.
  always_comb begin
    res_d    = res_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (accept) begin
      if (op_is_mul) begin
        mcand_d  = {{WIDTH{1'b0}}, A};
        mplier_d = B;
        acc_d    = '0;
        cnt_d    = CW'(WIDTH);
      end else begin
        res_d = alu_res;
        z_d   = (alu_res == '0);
        n_d   = alu_res[WIDTH-1];
        c_d   = alu_c;
        v_d   = alu_v;
      end
    end else if (state_q == StBusy) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (last_step) begin
        res_d = acc_step[WIDTH-1:0];
        z_d   = (acc_step[WIDTH-1:0] == '0);
        n_d   = acc_step[WIDTH-1];
        c_d   = |acc_step[2*WIDTH-1:WIDTH];
        v_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      res_q    <= res_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Result = res_q;
  assign FLAG_Z = z_q;
  assign FLAG_N = n_q;
  assign FLAG_C = c_q;
  assign FLAG_V = v_q;

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (WIDTH=8): directed vector table, hand-written handshake
// and reset sequences, and randomized operations against an arithmetic reference model.
module tb_ula_seq;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A, B;
  logic [2:0]   OP;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] Result;
  logic         FLAG_Z, FLAG_N, FLAG_C, FLAG_V;

  int checks = 0;
  int errors = 0;

  ula_seq #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Result    (Result),
    .FLAG_Z    (FLAG_Z),
    .FLAG_N    (FLAG_N),
    .FLAG_C    (FLAG_C),
    .FLAG_V    (FLAG_V)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;  // {Z, N, C, V}
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {FLAG_Z, FLAG_N, FLAG_C, FLAG_V};
  endfunction

  // Reference model from the opcode rules, in plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input int unsigned a, input int unsigned b,
                                output logic [W-1:0] res, output logic [3:0] flg);
    int unsigned r;
    int unsigned modv;
    int sa, sb, s, sh;
    bit c, v;
    modv = 1 << W;
    sa = (a >= modv / 2) ? int'(a) - int'(modv) : int'(a);
    sb = (b >= modv / 2) ? int'(b) - int'(modv) : int'(b);
    sh = int'(b % W);
    c = 0;
    v = 0;
    r = 0;
    case (op)
      3'd0: begin
        r = a + b; c = (r >= modv); s = sa + sb;
        v = (s > int'(modv / 2) - 1) || (s < -int'(modv / 2));
      end
      3'd1: begin
        r = a + modv - b; c = (a < b); s = sa - sb;
        v = (s > int'(modv / 2) - 1) || (s < -int'(modv / 2));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a << sh; c = (sh != 0) && (((a >> (W - sh)) & 1) == 1); end
      3'd6: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      default: begin r = a * b; c = (r >= modv); end
    endcase
    res = W'(r % modv);
    flg = {(res == 0), res[W-1], c, v};
  endfunction

  // Offer one operation with OUT_READY high, check latency, handshake and result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_res,
                        input logic [3:0] exp_flg);
    int n;
    int lat;
    bit ready_in_busy;
    IN_VALID  = 1'b1;
    A         = a;
    B         = b;
    OP        = op;
    OUT_READY = 1'b1;
    n = 0;
    while (!IN_READY && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    if (!IN_READY) begin
      chk({name, " accept timeout"}, 32'(IN_READY), 32'd1);
      IN_VALID = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    // Scramble the inputs: the operation in flight must not notice.
    IN_VALID = 1'b0;
    A  = W'($urandom);
    B  = W'($urandom);
    OP = 3'($urandom);
    lat = 0;
    ready_in_busy = 0;
    while (!OUT_VALID && lat < 50) begin
      if (IN_READY) ready_in_busy = 1;
      @(posedge CLK); #1; lat++;
    end
    chk({name, " latency"}, 32'(lat), (op == 3'd7) ? 32'(W) : 32'd0);
    if (op == 3'd7) chk({name, " IN_READY in busy"}, 32'(ready_in_busy), 32'd0);
    chk({name, " result"}, 32'(Result), 32'(exp_res));
    chk({name, " flags"}, 32'(flags()), 32'(exp_flg));
  endtask

  initial begin
    logic [W-1:0] mres;
    logic [3:0]   mflg;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    //             op     a      b      res    {Z,N,C,V}
    vecs[0] = '{3'd0, 8'd10, 8'd5,  8'h0F, 4'b0000};
    vecs[1] = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101};
    vecs[2] = '{3'd1, 8'd5,  8'd10, 8'hFB, 4'b0110};
    vecs[3] = '{3'd4, 8'hFF, 8'hFF, 8'h00, 4'b1000};
    vecs[4] = '{3'd7, 8'd13, 8'd11, 8'h8F, 4'b0100};
    vecs[5] = '{3'd7, 8'd16, 8'd17, 8'h10, 4'b0010};
    vecs[6] = '{3'd5, 8'h81, 8'd1,  8'h02, 4'b0010};
    vecs[7] = '{3'd6, 8'h5A, 8'd0,  8'h5A, 4'b0000};
    vecs[8] = '{3'd6, 8'h01, 8'd1,  8'h00, 4'b1010};
    vecs[9] = '{3'd3, 8'h0F, 8'hF0, 8'hFF, 4'b0100};

    // Reset state
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0; OP = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset IN_READY", 32'(IN_READY), 32'd0);
    chk("reset OUT_VALID", 32'(OUT_VALID), 32'd0);
    chk("reset Result", 32'(Result), 32'd0);
    chk("reset flags", 32'(flags()), 32'd0);
    RST = 1'b0;
    #1;
    chk("idle IN_READY", 32'(IN_READY), 32'd1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].flg);
    end

    // Output stall: AND held while an ADD waits
    @(posedge CLK); #1;  // drain to idle
    IN_VALID = 1'b1; OP = 3'd2; A = 8'hCC; B = 8'hAA; OUT_READY = 1'b0;
    chk("stall idle ready", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b1; OP = 3'd0; A = 8'h01; B = 8'h02;
    chk("stall AND flags", 32'(flags()), 32'b0100);
    for (int i = 0; i < 5; i++) begin
      chk("stall OUT_VALID", 32'(OUT_VALID), 32'd1);
      chk("stall Result", 32'(Result), 32'h88);
      chk("stall IN_READY", 32'(IN_READY), 32'd0);
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    #1;
    chk("stall release ready", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    chk("handoff OUT_VALID", 32'(OUT_VALID), 32'd1);
    chk("handoff Result", 32'(Result), 32'h03);
    chk("handoff flags", 32'(flags()), 32'd0);

    // Reset in the 4th busy cycle of a MUL
    IN_VALID = 1'b1; OP = 3'd7; A = 8'd200; B = 8'd3;
    while (!IN_READY) begin @(posedge CLK); #1; end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("rst busy IN_READY", 32'(IN_READY), 32'd0);
    @(posedge CLK); #1;
    chk("rst busy OUT_VALID", 32'(OUT_VALID), 32'd0);
    chk("rst busy Result", 32'(Result), 32'd0);
    chk("rst busy flags", 32'(flags()), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      chk("no stale OUT_VALID", 32'(OUT_VALID), 32'd0);
    end
    run_op("post-reset add", 3'd0, 8'd3, 8'd4, 8'd7, 4'b0000);

    // Randomized operations against the model
    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (i % 10 == 0) rb = W'(i / 10 % W);  // small shift amounts incl. 0
      model(rop, int'(ra), int'(rb), mres, mflg);
      run_op($sformatf("rnd%0d op%0d %0h,%0h", i, rop, ra, rb), rop, ra, rb, mres, mflg);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, registered successor to the 8-bit combinational ULA. It adds XOR, shift and a multi-cycle multiply, plus status flags and valid/ready handshakes on both input and output. It sits between an operand source and a result consumer, accepts one operation at a time, and holds each result until the consumer takes it.

Parameters:
WIDTH, 8, operand/result width in bits; must be a power of 2 and at least 4.
SHW, $clog2(WIDTH), shift-amount width (derived; never overridden).

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  reset, synchronous, active-high.
IN_VALID  input  1  operand/opcode offer.
IN_READY  output  1  block can accept an operation this cycle.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B; shift ops use only B[SHW-1:0].
OP  input  3  opcode.
OUT_VALID  output  1  Result and flags are valid.
OUT_READY  input  1  consumer takes the result this cycle.
Result  output  WIDTH  registered result.
FLAG_Z  output  1  Result == 0.
FLAG_N  output  1  Result[WIDTH-1].
FLAG_C  output  1  carry / borrow / shift-out / multiply high-half nonzero.
FLAG_V  output  1  signed overflow; ADD/SUB only, 0 otherwise.

Behaviour:
- Accept = IN_VALID && IN_READY at a rising edge. A, B and OP are captured only on accept.
- Opcodes:
  - 000 ADD: A+B mod 2^WIDTH. C = carry out. V = signed overflow.
  - 001 SUB: A-B mod 2^WIDTH. C = borrow (A<B unsigned). V = signed overflow.
  - 010 AND, 011 OR, 100 XOR: C=0, V=0.
  - 101 SHL logical by B[SHW-1:0]. C = last bit shifted out; C=0 when the shift amount is 0.
  - 110 SHR logical, same C rule.
  - 111 MUL unsigned, shift-add, one multiplier bit per cycle. Result = low WIDTH bits. C=1 if high WIDTH bits are nonzero. V=0.
- FSM states:
  - IDLE: IN_READY=1, OUT_VALID=0.
    - Accept of a non-MUL op: result and flags registered, go to DONE. OUT_VALID is visible in the cycle after accept (latency 1).
    - Accept of MUL: load multiplicand, multiplier and a 2*WIDTH accumulator, set counter=WIDTH, go to BUSY.
  - BUSY: IN_READY=0, OUT_VALID=0. Counter decrements each cycle. After exactly WIDTH BUSY cycles, go to DONE. A MUL accepted at edge N shows OUT_VALID at edge N+WIDTH+1.
  - DONE: OUT_VALID=1. Result and flags are stable while OUT_READY=0.
    - OUT_READY=1 and no accept: go to IDLE.
    - OUT_READY=1 and accept (IN_READY = OUT_READY in DONE): back-to-back handoff to the new op; OUT_VALID stays high for non-MUL ops.
    - OUT_READY=0: IN_READY=0.
- Flags Z and N are derived from the registered Result. All flags update only when a new result is registered.
- Reset:
  - While RST=1: IN_READY=0.
  - After reset: state IDLE, OUT_VALID=0, Result=0, all flags 0, counter and accumulator 0.
  - Reset in BUSY or DONE aborts and discards the operation. No stale result appears afterwards.
- IN_VALID while IN_READY=0 is ignored. The source must hold the offer.
- OP changes after accept have no effect on the operation in flight.

Test Plan:
1. WIDTH=8, ADD A=10 B=5, OUT_READY=1 -> Result=15, Z=N=C=V=0, OUT_VALID high exactly 1 cycle after accept.
2. ADD 8'h7F+8'h01 -> 8'h80, N=1 V=1 C=0. Then SUB 5-10 -> 8'hFB, C=1 N=1 V=0. Then XOR 8'hFF^8'hFF -> 0, Z=1.
3. MUL 13*11 -> Result=8'h8F, C=0, OUT_VALID exactly 9 cycles after accept, IN_READY=0 throughout BUSY. Then MUL 16*17 -> 8'h10, C=1.
4. AND 8'hCC&8'hAA with OUT_READY=0 for 5 cycles, then ADD offered meanwhile -> Result holds 8'h88, IN_READY=0. ADD is accepted on the cycle OUT_READY rises and its result appears on the next cycle.
5. SHL 8'b10000001 by 1 -> 8'b00000010, C=1. SHR 8'h5A by 0 -> 8'h5A, C=0. SHR 8'h01 by 1 -> 0, Z=1 C=1.
6. RST=1 in the 4th BUSY cycle of a MUL -> next cycle OUT_VALID=0, Result=0, flags 0. A subsequent ADD 3+4 -> 7 with normal latency.
